// File: rtl/ooo_pkg.sv
// Types and widths shared by the out-of-order core's dispatch, rename and retire logic.
package ooo_pkg;
    localparam int NUM_ROB_ENTRIES      = 64;
    localparam int NUM_FUNCTIONAL_UNITS = 3;
    localparam int PREG_W               = 6;
    localparam int ROB_IDX_W            = 6;
    localparam int ROB_PTR_W            = ROB_IDX_W + 1;
    localparam int DATA_W               = 32;
    localparam int ARCH_REG_W           = 5;

    typedef struct packed {
        logic                  busy;
        logic                  done;
        logic                  has_dest;
        logic [ARCH_REG_W-1:0] arch_dest;
        logic [PREG_W-1:0]     phys_dest;
        logic [PREG_W-1:0]     old_phys_dest;
        logic [DATA_W-1:0]     value;
    } rob_entry_t;
endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate, out-of-order writeback, in-order
// single-entry retire with commit and free-list return.
module reorder_buffer
    import ooo_pkg::*;
(
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   flush,
    input  logic                                   alloc_valid,
    input  logic                                   alloc_has_dest,
    input  logic [ARCH_REG_W-1:0]                  alloc_arch_dest,
    input  logic [PREG_W-1:0]                      alloc_phys_dest,
    input  logic [PREG_W-1:0]                      alloc_old_phys_dest,
    output logic                                   alloc_ready,
    output logic [ROB_IDX_W-1:0]                   alloc_rob_index,
    input  logic [NUM_FUNCTIONAL_UNITS-1:0]        wb_valid,
    input  logic [NUM_FUNCTIONAL_UNITS*ROB_IDX_W-1:0] wb_rob_index,
    input  logic [NUM_FUNCTIONAL_UNITS*DATA_W-1:0] wb_value,
    output logic                                   commit_valid,
    output logic                                   commit_has_dest,
    output logic [ARCH_REG_W-1:0]                  commit_arch_dest,
    output logic [PREG_W-1:0]                      commit_phys_dest,
    output logic [DATA_W-1:0]                      commit_value,
    output logic                                   free_valid,
    output logic [PREG_W-1:0]                      free_phys_reg,
    output logic                                   rob_full,
    output logic                                   rob_empty,
    output logic [ROB_PTR_W-1:0]                   rob_count
);
    logic [ROB_PTR_W-1:0] head_q, tail_q;
    rob_entry_t           rob_q [NUM_ROB_ENTRIES];
    rob_entry_t           head_entry;
    rob_entry_t           new_entry;
    logic [ROB_IDX_W-1:0] head_idx, tail_idx;
    logic                 alloc_fire, retire;

    assign head_idx        = head_q[ROB_IDX_W-1:0];
    assign tail_idx        = tail_q[ROB_IDX_W-1:0];
    assign rob_count       = tail_q - head_q;
    assign rob_empty       = (head_q == tail_q);
    assign rob_full        = (head_idx == tail_idx) && (head_q[ROB_IDX_W] != tail_q[ROB_IDX_W]);
    assign alloc_ready     = !rob_full;
    assign alloc_rob_index = tail_idx;
    assign alloc_fire      = alloc_valid && alloc_ready;
    assign head_entry      = rob_q[head_idx];
    assign retire          = head_entry.busy && head_entry.done;

    always_comb begin
        new_entry               = '0;
        new_entry.busy          = 1'b1;
        new_entry.has_dest      = alloc_has_dest;
        new_entry.arch_dest     = alloc_arch_dest;
        new_entry.phys_dest     = alloc_phys_dest;
        new_entry.old_phys_dest = alloc_old_phys_dest;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q           <= '0;
            tail_q           <= '0;
            for (int i = 0; i < NUM_ROB_ENTRIES; i++) rob_q[i] <= '0;
            commit_valid     <= 1'b0;
            commit_has_dest  <= 1'b0;
            commit_arch_dest <= '0;
            commit_phys_dest <= '0;
            commit_value     <= '0;
            free_valid       <= 1'b0;
            free_phys_reg    <= '0;
        end else if (flush) begin
            head_q       <= '0;
            tail_q       <= '0;
            for (int i = 0; i < NUM_ROB_ENTRIES; i++) begin
                rob_q[i].busy <= 1'b0;
                rob_q[i].done <= 1'b0;
            end
            commit_valid <= 1'b0;
            free_valid   <= 1'b0;
        end else begin
            // Ascending port order so the highest-numbered port wins a shared index.
            for (int p = 0; p < NUM_FUNCTIONAL_UNITS; p++) begin
                if (wb_valid[p] && rob_q[wb_rob_index[p*ROB_IDX_W +: ROB_IDX_W]].busy) begin
                    rob_q[wb_rob_index[p*ROB_IDX_W +: ROB_IDX_W]].done  <= 1'b1;
                    rob_q[wb_rob_index[p*ROB_IDX_W +: ROB_IDX_W]].value <= wb_value[p*DATA_W +: DATA_W];
                end
            end
            if (alloc_fire) begin
                rob_q[tail_idx] <= new_entry;
                tail_q          <= tail_q + 1'b1;
            end
            if (retire) begin
                rob_q[head_idx].busy <= 1'b0;
                head_q               <= head_q + 1'b1;
                commit_valid         <= 1'b1;
                commit_has_dest      <= head_entry.has_dest;
                commit_arch_dest     <= head_entry.arch_dest;
                commit_phys_dest     <= head_entry.phys_dest;
                commit_value         <= head_entry.value;
                free_valid           <= head_entry.has_dest && (head_entry.old_phys_dest != '0);
                free_phys_reg        <= head_entry.old_phys_dest;
            end else begin
                commit_valid <= 1'b0;
                free_valid   <= 1'b0;
            end
        end
    end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order reorder buffer for the out-of-order RISC-V core.
- Sits beside the issue queue at dispatch. It supplies ROB_entry_index for each dispatched instruction, accepts out-of-order writeback from the functional units, and retires in program order.
- On retire, it drives architectural commit and returns the stale physical register to the rename free list.

Parameters:
- NUM_ROB_ENTRIES, 64, entries; power of two.
- NUM_FUNCTIONAL_UNITS, 3, writeback ports.
- NUM_PHYSICAL_REGS, 64, physical register file size; PREG_W = 6.
- DATA_W, 32, result width.

Ports:
- clk  input  1  single clock; rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous squash of all entries.
- alloc_valid  input  1  dispatch request.
- alloc_has_dest  input  1  instruction writes a register.
- alloc_arch_dest  input  5  architectural rd.
- alloc_phys_dest  input  6  new physical destination.
- alloc_old_phys_dest  input  6  previous mapping of rd.
- alloc_ready  output  1  equals !rob_full (combinational).
- alloc_rob_index  output  6  tail index granted to this alloc (combinational).
- wb_valid  input  NUM_FUNCTIONAL_UNITS  per-port result valid.
- wb_rob_index  input  NUM_FUNCTIONAL_UNITS*6  per-port target entry.
- wb_value  input  NUM_FUNCTIONAL_UNITS*32  per-port result.
- commit_valid  output  1  one retirement this cycle (registered).
- commit_has_dest  output  1  retired entry writes a register.
- commit_arch_dest  output  5  architectural rd.
- commit_phys_dest  output  6  physical rd.
- commit_value  output  32  result value.
- free_valid  output  1  return a register to the free list (registered).
- free_phys_reg  output  6  register being freed.
- rob_full  output  1  count == NUM_ROB_ENTRIES.
- rob_empty  output  1  count == 0.
- rob_count  output  7  occupied entries.

Behaviour:
- State:
  - head/tail pointers, 7 bits each; the MSB is the wrap bit.
  - count = tail - head.
  - Full when the index bits are equal and the wrap bits differ. Empty when head == tail.
- Reset (async):
  - head = tail = 0; all busy/done bits cleared.
  - All registered outputs are 0.
  - rob_empty=1, alloc_ready=1, rob_full=0, rob_count=0.
- Allocate:
  - At the edge where alloc_valid && alloc_ready: write the entry at tail[5:0] with busy=1, done=0 and the dest fields, then tail++.
  - alloc_rob_index = tail[5:0] at all times.
  - alloc_valid while full is ignored; no state change.
- Writeback:
  - At each edge, for each port p with wb_valid[p]: if entry wb_rob_index[p] is busy, set done=1 and store the value.
  - A writeback to a non-busy entry is ignored.
  - Two ports targeting the same index in one cycle: the higher port number wins.
- Retire (one per cycle):
  - At edge E, if head entry busy && done (state before E):
    - clear busy; head++;
    - commit_valid<=1 and commit_* <= entry fields.
    - free_valid <= has_dest && old_phys_dest != 0; free_phys_reg <= old_phys_dest.
  - Otherwise commit_valid<=0 and free_valid<=0.
  - A writeback sampled at edge E to the head entry retires at edge E+1; commit_valid is visible during the cycle after E+1.
- Simultaneous alloc and retire:
  - Both take effect at the same edge; count is unchanged.
  - If full at that edge, alloc is still rejected, because alloc_ready reflects pre-edge state.
- Wrap-around: pointers wrap 127->0. Index 63 is followed by index 0, with the wrap bit toggled.
- Flush:
  - Highest priority. At the edge, head=tail=0, all busy/done cleared, commit_valid<=0, free_valid<=0.
  - Alloc, writeback and retire in the same cycle are discarded.
- Reset mid-operation: state clears immediately (async); no partial commit is emitted.

Decomposition:
- Shared package ooo_pkg holds:
  - PREG_W, ROB_IDX_W, DATA_W, ARCH_REG_W;
  - rob_entry_t struct: busy, done, has_dest, arch_dest, phys_dest, old_phys_dest, value.
- The issue queue and rename stage import the same package.
- No sub-module: the storage array, pointer logic and writeback priority fit in one module.

Test Plan:
- Reset, then alloc x1 (preg 10, old 1) and x3 (preg 11, old 3) -> alloc_rob_index 0, then 1; rob_count=2; rob_empty=0.
- Writeback to idx 1 (value 17) before idx 0 -> no commit. Then writeback to idx 0 (value 42) -> commit x1/p10/42 one cycle later, then x3/p11/17 the next cycle; free_phys_reg 1, then 3.
- Alloc 64 entries with no writebacks -> rob_full=1, alloc_ready=0. 65th alloc_valid -> rob_count stays 64, tail unchanged.
- Full ROB with idx 0 done, alloc_valid held -> retire of idx 0 and alloc rejected in that cycle. Next cycle alloc accepted at index 0 with wrap bit set.
- Ports 0 and 2 write the same busy index with 5 and 9 -> committed value 9. Writeback to an unallocated index -> no effect.
- Alloc 4 entries, writeback 2 of them, then pulse flush -> rob_empty=1, no commit_valid, next alloc_rob_index=0. Assert reset_n=0 mid-stream -> outputs 0 immediately.
